// File: rtl/display_pkg.sv
// Shared definitions for the scanned seven-segment display controller:
// register map, CTRL layout, scan FSM encoding and pin polarity helpers.
package display_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEG_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_DIG0   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd5;

    localparam int unsigned CTRL_EN        = 0;
    localparam int unsigned CTRL_DEC       = 1;
    localparam int unsigned CTRL_BLINK_LSB = 2;
    localparam int unsigned CTRL_W         = 8;

    typedef struct packed {
        logic [5:0] blink_mask;
        logic       decode_en;
        logic       enable;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // Convert an active-high segment pattern to pin level.
    function automatic logic [SEG_W-1:0] seg_to_pin(input logic [SEG_W-1:0] pat,
                                                    input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

    // Pin level for all segments off.
    function automatic logic [SEG_W-1:0] seg_off_pin(input logic active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Avalon-MM register port of the display scan controller.
interface display_scan_ctrl_if;
    import display_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/display_scan_ctrl_hex7seg.sv
// Hex nibble to active-high seven-segment pattern (bit0=a .. bit6=g).
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    always_comb begin
        seg_c = 7'h00;
        unique case (nibble)
            4'h0: seg_c = 7'h3F;
            4'h1: seg_c = 7'h06;
            4'h2: seg_c = 7'h5B;
            4'h3: seg_c = 7'h4F;
            4'h4: seg_c = 7'h66;
            4'h5: seg_c = 7'h6D;
            4'h6: seg_c = 7'h7D;
            4'h7: seg_c = 7'h07;
            4'h8: seg_c = 7'h7F;
            4'h9: seg_c = 7'h6F;
            4'hA: seg_c = 7'h77;
            4'hB: seg_c = 7'h7C;
            4'hC: seg_c = 7'h39;
            4'hD: seg_c = 7'h5E;
            4'hE: seg_c = 7'h79;
            4'hF: seg_c = 7'h71;
            default: seg_c = 7'h00;
        endcase
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with dead-time blanking, optional
// hex decode and per-digit blink, controlled through an Avalon-MM register slave.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned SCAN_DIV         = 50000,
    parameter int unsigned BLANK_CYCLES     = 500,
    parameter int unsigned BLINK_FRAMES     = 256,
    parameter int unsigned SEG_ACTIVE_LOW   = 1,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    display_scan_ctrl_if.slave    bus,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] digit_sel
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic             SEG_LOW    = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

    logic [SEG_W-1:0]      digit_q [NUM_DIGITS];
    ctrl_t                 ctrl_q;
    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_q, phase_d;
    logic [SEG_W-1:0]      shadow_q, shadow_d;
    logic [SEG_W-1:0]      seg_d;
    logic [NUM_DIGITS-1:0] dsel_d;
    logic [SEG_W-1:0]      cur_digit;
    logic [6:0]            hex_seg;
    logic [SEG_W-1:0]      snap_pat;
    logic                  wr_en;
    logic                  unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata[DATA_W-1:SEG_W];

    // Register file writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) digit_q[i] <= '0;
            ctrl_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++)
                if (bus.address == 3'(i)) digit_q[i] <= bus.writedata[SEG_W-1:0];
            if (bus.address == ADDR_CTRL) ctrl_q <= ctrl_t'(bus.writedata[CTRL_W-1:0]);
        end
    end

    // Zero-wait-state read mux; unmapped addresses read as zero
    always_comb begin
        bus.readdata = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++)
            if (bus.address == 3'(i)) bus.readdata = DATA_W'(digit_q[i]);
        if (bus.address == ADDR_CTRL)   bus.readdata = DATA_W'(ctrl_q);
        if (bus.address == ADDR_STATUS) bus.readdata = DATA_W'({phase_q, idx_q});
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++)
            if (idx_q == 3'(i)) cur_digit = digit_q[i];
    end

    hex7seg hex_u (.nibble(cur_digit[3:0]), .seg_c(hex_seg));

    assign snap_pat = ctrl_q.decode_en ? {cur_digit[7], hex_seg} : cur_digit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frm_q     <= '0;
            phase_q   <= 1'b0;
            shadow_q  <= '0;
            seg_out   <= seg_off_pin(SEG_LOW);
            digit_sel <= DIG_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frm_q     <= frm_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            seg_out   <= seg_d;
            digit_sel <= dsel_d;
        end
    end

    // Scan sequencing; pin values are computed for the next state so they align with it
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frm_d    = frm_q;
        phase_d  = phase_q;
        shadow_d = shadow_q;
        seg_d    = seg_off_pin(SEG_LOW);
        dsel_d   = DIG_OFF;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q.enable) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == BLANK_LAST) begin
                    state_d  = ST_DRIVE;
                    shadow_d = snap_pat;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (frm_q == FRM_LAST) begin
                            frm_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            frm_d = frm_q + FRM_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!ctrl_q.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            frm_d   = '0;
            phase_d = 1'b0;
        end

        if (state_d == ST_DRIVE) begin
            seg_d = seg_to_pin((ctrl_q.blink_mask[idx_q] & phase_q) ? '0 : shadow_d, SEG_LOW);
            dsel_d = DIG_OFF ^ (NUM_DIGITS'(1) << idx_q);
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a slot-arithmetic reference model.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int N  = 4;
    localparam int S  = 8;
    localparam int B  = 2;
    localparam int BF = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   seg_out;
    logic [N-1:0] digit_sel;

    always #5 clk = ~clk;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave),
        .seg_out(seg_out), .digit_sel(digit_sel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[v];
    endfunction

    // Reference model: scan position derived from cycles elapsed since enable
    logic [7:0]   m_dig [N] = '{default: 8'h00};
    logic [7:0]   m_ctrl = 8'h00;
    bit           m_run = 0;
    int           m_t = 0;
    logic [7:0]   m_snap = 8'h00;
    int           m_idx = 0;
    int           m_phase = 0;
    logic [7:0]   exp_seg = 8'hFF;
    logic [N-1:0] exp_dsel = '1;

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        if (int'(a) < N) return 32'(m_dig[a[1:0]]);
        if (a == 3'd4)   return 32'(m_ctrl);
        if (a == 3'd5)   return 32'(m_phase * 8 + m_idx);
        return 32'h0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) m_dig[i] = 8'h00;
            m_ctrl = 8'h00; m_run = 0; m_t = 0; m_snap = 8'h00;
            m_idx = 0; m_phase = 0; exp_seg = 8'hFF; exp_dsel = '1;
        end else begin
            int slot, pos, idx, ph;
            logic [7:0] pat;
            if (!m_ctrl[0]) begin m_run = 0; m_t = 0; end
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
            slot = m_t / S; pos = m_t % S; idx = slot % N; ph = (slot / N / BF) % 2;
            if (m_run && pos == B)
                m_snap = m_ctrl[1] ? {m_dig[idx][7], hex(m_dig[idx][3:0])} : m_dig[idx];
            exp_seg = 8'hFF; exp_dsel = '1;
            if (m_run && pos >= B) begin
                pat = (m_ctrl[2 + idx] && ph == 1) ? 8'h00 : m_snap;
                exp_seg = ~pat;
                exp_dsel = ~(N'(1) << idx);
            end
            m_idx = m_run ? idx : 0;
            m_phase = m_run ? ph : 0;
            if (bus.chipselect && !bus.write_n) begin
                if (int'(bus.address) < N) m_dig[bus.address[1:0]] = bus.writedata[7:0];
                else if (bus.address == 3'd4) m_ctrl = bus.writedata[7:0];
            end
        end
        #1;
        check("seg_out", 32'(seg_out), 32'(exp_seg));
        check("digit_sel", 32'(digit_sel), 32'(exp_dsel));
        check("readdata", bus.readdata, exp_rd(bus.address));
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic wait_sel(input string name, input logic [N-1:0] target);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (digit_sel == target) break;
        end
        check(name, 32'(digit_sel), 32'(target));
    endtask

    task automatic wait_phase1();
        @(negedge clk); bus.address = 3'd5;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (bus.readdata[3]) break;
        end
        check("phase_up", 32'(bus.readdata[3]), 32'd1);
    endtask

    initial begin
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Idle: inactive pins and zero reads everywhere
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); bus.address = 3'(i % 8);
            @(posedge clk); #2;
            check("idle_rd", bus.readdata, 32'h0);
            check("idle_seg", 32'(seg_out), 32'hFF);
            check("idle_sel", 32'(digit_sel), 32'hF);
        end

        // Decoded scan of 1,2,3,4
        wr(3'd0, 1); wr(3'd1, 2); wr(3'd2, 3); wr(3'd3, 4); wr(3'd4, 3);
        wait_sel("sel_d0", 4'hE); check("seg_d0", 32'(seg_out), 32'hF9);
        wait_sel("sel_d1", 4'hD); check("seg_d1", 32'(seg_out), 32'hA4);
        wait_sel("sel_d2", 4'hB); check("seg_d2", 32'(seg_out), 32'hB0);
        wait_sel("sel_d3", 4'h7); check("seg_d3", 32'(seg_out), 32'h99);
        wait_sel("sel_d0b", 4'hE); check("seg_d0b", 32'(seg_out), 32'hF9);

        // Raw mode, dp only on digit 2
        wr(3'd4, 1); wr(3'd2, 8'h80);
        repeat (40) @(negedge clk);
        wait_sel("sel_raw", 4'hB); check("seg_raw", 32'(seg_out), 32'h7F);

        // Mid-slot write does not tear the current slot
        wr(3'd2, 3); wr(3'd4, 3);
        repeat (40) @(negedge clk);
        wait_sel("sel_tear", 4'hD);
        wr(3'd1, 5);
        check("seg_notear", 32'(seg_out), 32'hA4);
        wait_sel("sel_next", 4'hE);
        wait_sel("sel_new", 4'hD); check("seg_new", 32'(seg_out), 32'h92);

        // Blink digit 1
        wr(3'd4, 32'h0B);
        wait_phase1();
        wait_sel("sel_bl0", 4'hE); check("seg_bl0", 32'(seg_out), 32'hF9);
        wait_sel("sel_bl1", 4'hD); check("seg_bl1", 32'(seg_out), 32'hFF);
        repeat (200) @(negedge clk);

        // Disable mid-drive, then re-enable
        wr(3'd4, 3);
        wait_sel("sel_dis", 4'hB);
        wr(3'd4, 0);
        @(posedge clk); #2;
        check("dis_sel", 32'(digit_sel), 32'hF);
        check("dis_seg", 32'(seg_out), 32'hFF);
        @(negedge clk); bus.address = 3'd5;
        @(posedge clk); #2;
        check("dis_status", bus.readdata, 32'h0);
        wr(3'd4, 3);
        wait_sel("sel_reen", 4'hE); check("seg_reen", 32'(seg_out), 32'hF9);

        // Asynchronous reset mid-slot
        wait_sel("sel_rst", 4'h7);
        #1 reset_n = 1'b0;
        #1;
        check("rst_sel", 32'(digit_sel), 32'hF);
        check("rst_seg", 32'(seg_out), 32'hFF);
        @(negedge clk); reset_n = 1'b1; bus.address = 3'd4;
        @(posedge clk); #2;
        check("rst_ctrl", bus.readdata, 32'h0);

        // Random register traffic
        wr(3'd4, 3);
        for (int it = 0; it < 400; it++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd4 && $urandom_range(0, 7) != 0) d[0] = 1'b1;
            wr(a, d);
            repeat ($urandom_range(0, 6)) begin
                @(negedge clk); bus.address = 3'($urandom_range(0, 7));
            end
        end
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
